sram_bus_arbiter: RTL

// - Shares one SRAM-like memory port between instruction fetch (IF) and data access (EX/MEM).
// - Arbitrates requests and forwards the winner downstream with the req/addr_ok/data_ok handshake.
// - Records the owner of every accepted request in an in-order FIFO and returns each data_ok/rdata to that owner.
// - Sits between the pipeline stages and the memory bridge.

---
 rtl/sram_bus_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access, returning responses in order.
// Define SRAM_ARB_RR_EN for round-robin arbitration; by default the data side has fixed priority.
module sram_bus_arbiter #(
   parameter int MAX_OUTST = 2,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_addr_ok,
   output logic              i_data_ok,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [1:0]        d_size,
   input  logic [3:0]        d_wstrb,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_addr_ok,
   output logic              d_data_ok,
   output logic [31:0]       d_rdata,
   output logic              m_req,
   output logic              m_wr,
   output logic [1:0]        m_size,
   output logic [3:0]        m_wstrb,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   input  logic              m_addr_ok,
   input  logic              m_data_ok,
   input  logic [31:0]       m_rdata,
   output logic              err_spur
);
   localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int CNT_W = $clog2(MAX_OUTST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);

   typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} lock_t;

   lock_t                lock_q, lock_d;
   logic [MAX_OUTST-1:0] own_q, own_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
`ifdef SRAM_ARB_RR_EN
   logic                 last_d_q, last_d_d;
`endif

   logic sel_d_side;
   logic sel_vld;
   logic can_accept;
   logic xfer;
   logic pop;
   logic head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // A locked grant keeps presenting its owner until the downstream accepts it.
   always_comb begin
      sel_d_side = 1'b0;
      sel_vld    = 1'b0;
      unique case (lock_q)
         LOCK_I: begin
            sel_d_side = 1'b0;
            sel_vld    = i_req;
         end
         LOCK_D: begin
            sel_d_side = 1'b1;
            sel_vld    = d_req;
         end
         default: begin
`ifdef SRAM_ARB_RR_EN
            sel_d_side = d_req && (!i_req || !last_d_q);
`else
            sel_d_side = d_req;
`endif
            sel_vld    = i_req || d_req;
         end
      endcase
   end

   assign pop        = resetn && m_data_ok && (count_q != '0);
   assign head       = own_q[rd_ptr_q];
   // A pop in the same cycle frees a slot, so a full FIFO may still accept.
   assign can_accept = (count_q != CNT_MAX) || pop;
   assign m_req      = resetn && sel_vld && can_accept;
   assign xfer       = m_req && m_addr_ok;

   assign m_wr    = sel_d_side && d_wr;
   assign m_size  = sel_d_side ? d_size  : 2'd2;
   assign m_wstrb = sel_d_side ? d_wstrb : 4'd0;
   assign m_addr  = sel_d_side ? d_addr  : i_addr;
   assign m_wdata = sel_d_side ? d_wdata : 32'd0;

   assign i_addr_ok = xfer && !sel_d_side;
   assign d_addr_ok = xfer && sel_d_side;
   assign i_data_ok = pop && !head;
   assign d_data_ok = pop && head;
   assign i_rdata   = i_data_ok ? m_rdata : 32'd0;
   assign d_rdata   = d_data_ok ? m_rdata : 32'd0;
   assign err_spur  = resetn && m_data_ok && (count_q == '0);

   always_comb begin
      lock_d   = lock_q;
      own_d    = own_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
`ifdef SRAM_ARB_RR_EN
      last_d_d = last_d_q;
`endif
      if (lock_q == IDLE) begin
         if (m_req && !m_addr_ok)
            lock_d = sel_d_side ? LOCK_D : LOCK_I;
      end else if (xfer) begin
         lock_d = IDLE;
      end
      if (xfer) begin
         own_d[wr_ptr_q] = sel_d_side;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
`ifdef SRAM_ARB_RR_EN
         last_d_d        = sel_d_side;
`endif
      end
      if (pop)
         rd_ptr_d = ptr_inc(rd_ptr_q);
      if (xfer && !pop)
         count_d = count_q + CNT_W'(1);
      else if (!xfer && pop)
         count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         lock_q   <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
`ifdef SRAM_ARB_RR_EN
         last_d_q <= 1'b0;
`endif
      end else begin
         lock_q   <= lock_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
`ifdef SRAM_ARB_RR_EN
         last_d_q <= last_d_d;
`endif
      end
   end

   // Owner storage is only meaningful below count_q, so it needs no reset.
   always_ff @(posedge clk) begin
      own_q <= own_d;
   end

endmodule
